// File: rtl/ex_dispatch.sv
// In-order dispatch queue: buffers {payload, lane} packets and offers the oldest
// to exactly one of three functional-unit lanes; lane code 3 is dropped with a pulse.
module ex_dispatch #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic [DATA_W-1:0]          in_data,
  input  logic [1:0]                 in_fu_sel,
  output logic                       in_ready,
  input  logic                       flush,
  output logic [2:0]                 fu_valid,
  input  logic [2:0]                 fu_ready,
  output logic [DATA_W-1:0]          fu_data,
  output logic                       drop_err,
  output logic [$clog2(DEPTH):0]     occupancy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [DATA_W-1:0] r_data [DEPTH];
  logic [1:0]        r_sel  [DEPTH];
  logic [PTR_W-1:0]  r_head;
  logic [PTR_W-1:0]  r_tail;
  logic [CNT_W-1:0]  r_count;

  logic              w_nonempty;
  logic [1:0]        w_head_sel;
  logic [DATA_W-1:0] w_head_data;
  logic              w_push;
  logic              w_pop;
  logic [2:0]        w_offer;

  assign w_nonempty  = (r_count != '0);
  assign w_head_sel  = r_sel[r_head];
  assign w_head_data = r_data[r_head];

  // A full queue never accepts, even when the head leaves in the same cycle.
  assign in_ready  = (r_count < FULL_CNT) && !flush;
  assign w_push    = in_valid && in_ready;
  assign occupancy = r_count;

  always_comb begin
    w_offer  = 3'b000;
    drop_err = 1'b0;
    fu_data  = '0;
    if (w_nonempty) begin
      fu_data = w_head_data;
      if (w_head_sel == 2'd3) begin
        drop_err = 1'b1;
      end else begin
        w_offer = 3'(3'b001 << w_head_sel);
      end
    end
  end

  assign fu_valid = w_offer;
  // Only the offered lane's ready matters; an illegal head retires unconditionally.
  assign w_pop    = (|(w_offer & fu_ready)) || drop_err;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + PTR_W'(1);
      if (w_pop)  r_head <= r_head + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is not scrubbed on pop or flush; r_count alone marks valid entries.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_data[i] <= '0;
        r_sel[i]  <= 2'd0;
      end
    end else if (w_push) begin
      r_data[r_tail] <= in_data;
      r_sel[r_tail]  <= in_fu_sel;
    end
  end

endmodule
